// File: rtl/rcv_if.sv
// Consumer-side bundle of the serial receiver: held byte, status flags and the
// read acknowledge. The receiver uses the master view, the consumer the slave view.
interface rcv_if;
  logic       read;
  logic       full;
  logic [7:0] parallel_out;
  logic       overrun;
  logic       framing_err;

  modport master (
    input  read,
    output full,
    output parallel_out,
    output overrun,
    output framing_err
  );

  modport slave (
    output read,
    input  full,
    input  parallel_out,
    input  overrun,
    input  framing_err
  );
endinterface

// File: rtl/rcv.sv
// Asynchronous 8N1 serial receiver. The line is synchronized, the start bit is
// confirmed at mid-bit, eight data bits are sampled LSB first at mid-bit and the
// stop bit decides between delivering the byte and flagging a framing error.
// The receiver never waits on the consumer: a new byte overwrites an unread one.
module rcv #(
  parameter int BIT_TICKS  = 1303,
  parameter int HALF_TICKS = 651
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  serial_in,
  rcv_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

  localparam logic [10:0] BIT_LOAD  = 11'(BIT_TICKS - 1);
  localparam logic [10:0] HALF_LOAD = 11'(HALF_TICKS - 1);

  logic        syncMeta_q;
  logic        syncOut_q;
  state_e      state_q;
  logic [10:0] count_q;
  logic [2:0]  bitIndex_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        full_q;
  logic        overrun_q;
  logic        framingErr_q;

  logic s;
  logic countZero;

  assign s         = syncOut_q;
  assign countZero = (count_q == 11'd0);

  // Two-flop synchronizer for the asynchronous line, parked at the idle level.
  always_ff @(posedge clk) begin
    if (reset) begin
      syncMeta_q <= 1'b1;
      syncOut_q  <= 1'b1;
    end else begin
      syncMeta_q <= serial_in;
      syncOut_q  <= syncMeta_q;
    end
  end

  // Frame FSM together with the held byte and the sticky status flags; a read
  // clears first so that a completing byte or framing error in the same cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= 11'd0;
      bitIndex_q   <= 3'd0;
      shift_q      <= 8'h00;
      data_q       <= 8'h00;
      full_q       <= 1'b0;
      overrun_q    <= 1'b0;
      framingErr_q <= 1'b0;
    end else begin
      if (bus.read) begin
        full_q       <= 1'b0;
        overrun_q    <= 1'b0;
        framingErr_q <= 1'b0;
      end

      if ((state_q != IDLE) && (state_q != BREAK) && !countZero) begin
        count_q <= count_q - 11'd1;
      end

      unique case (state_q)
        IDLE: begin
          if (!s) begin
            state_q <= START;
            count_q <= HALF_LOAD;
          end
        end

        START: begin
          if (countZero) begin
            if (s) begin
              state_q <= IDLE;
            end else begin
              state_q    <= DATA;
              count_q    <= BIT_LOAD;
              bitIndex_q <= 3'd0;
            end
          end
        end

        DATA: begin
          if (countZero) begin
            shift_q <= {s, shift_q[7:1]};
            count_q <= BIT_LOAD;
            if (bitIndex_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bitIndex_q <= bitIndex_q + 3'd1;
            end
          end
        end

        STOP: begin
          if (countZero) begin
            if (s) begin
              data_q  <= shift_q;
              full_q  <= 1'b1;
              state_q <= IDLE;
              if (full_q && !bus.read) begin
                overrun_q <= 1'b1;
              end
            end else begin
              framingErr_q <= 1'b1;
              state_q      <= BREAK;
            end
          end
        end

        BREAK: begin
          if (s) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.full         = full_q;
  assign bus.parallel_out = data_q;
  assign bus.overrun      = overrun_q;
  assign bus.framing_err  = framingErr_q;

endmodule

// File: tb/tb_rcv.sv
// Directed bench for rcv. One instance runs at the default bit timing for the
// exact completion-latency and start-glitch cases; a second instance with a short
// bit time covers framing, overrun, read collisions and mid-frame reset.
module tb_rcv;

  localparam int FULL_BIT  = 1303;
  localparam int FULL_HALF = 651;
  localparam int FAST_BIT  = 16;
  localparam int FAST_HALF = 8;

  logic clk;
  logic reset;
  logic serFull;
  logic serFast;

  int checks;
  int errors;

  rcv_if busFull ();
  rcv_if busFast ();

  rcv uFull (
    .clk       (clk),
    .reset     (reset),
    .serial_in (serFull),
    .bus       (busFull)
  );

  rcv #(
    .BIT_TICKS  (FAST_BIT),
    .HALF_TICKS (FAST_HALF)
  ) uFast (
    .clk       (clk),
    .reset     (reset),
    .serial_in (serFast),
    .bus       (busFast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Sends one frame, one line value per falling edge. Completion lands on the
  // rising edge 3 + HALF + 9*BIT after the start bit is first driven.
  task automatic applyStimulus(input bit fast, input logic [7:0] dataByte, input bit stopBit,
                               input bit pulseRead, input int stopAfter, input bit checkTiming);
    int   bt;
    int   ht;
    int   complete;
    int   limit;
    int   pos;
    logic lineVal;
    logic readVal;
    bt       = fast ? FAST_BIT : FULL_BIT;
    ht       = fast ? FAST_HALF : FULL_HALF;
    complete = 3 + ht + 9 * bt;
    limit    = (stopAfter == 0) ? 10 * bt : stopAfter;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (checkTiming && (c == complete - 1)) begin
        checkOutput("full_one_before_done", 8'(fast ? busFast.full : busFull.full), 8'h00);
      end
      if (checkTiming && (c == complete)) begin
        checkOutput("full_at_done", 8'(fast ? busFast.full : busFull.full), 8'h01);
      end
      pos = c / bt;
      if (pos == 0) begin
        lineVal = 1'b0;
      end else if (pos <= 8) begin
        lineVal = dataByte[3'(pos - 1)];
      end else begin
        lineVal = stopBit;
      end
      readVal = pulseRead && (c == complete - 1);
      if (fast) begin
        serFast      = lineVal;
        busFast.read = readVal;
      end else begin
        serFull      = lineVal;
        busFull.read = readVal;
      end
    end
    if (fast) begin
      serFast      = 1'b1;
      busFast.read = 1'b0;
    end else begin
      serFull      = 1'b1;
      busFull.read = 1'b0;
    end
  endtask

  task automatic readPulse();
    @(negedge clk);
    busFast.read = 1'b1;
    @(negedge clk);
    busFast.read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    serFull      = 1'b1;
    serFast      = 1'b1;
    busFull.read = 1'b0;
    busFast.read = 1'b0;

    idle(3);
    $display("[TB] reset values");
    checkOutput("rst_full",   8'(busFull.full), 8'h00);
    checkOutput("rst_data",   busFull.parallel_out, 8'h00);
    checkOutput("rst_ovr",    8'(busFull.overrun), 8'h00);
    checkOutput("rst_ferr",   8'(busFull.framing_err), 8'h00);
    checkOutput("rst_full_f", 8'(busFast.full), 8'h00);
    checkOutput("rst_data_f", busFast.parallel_out, 8'h00);
    reset = 1'b0;
    idle(2);

    $display("[TB] 0x55 at default bit time");
    applyStimulus(1'b0, 8'h55, 1'b1, 1'b0, 0, 1'b1);
    checkOutput("f55_data", busFull.parallel_out, 8'h55);
    checkOutput("f55_full", 8'(busFull.full), 8'h01);
    checkOutput("f55_ovr",  8'(busFull.overrun), 8'h00);
    checkOutput("f55_ferr", 8'(busFull.framing_err), 8'h00);

    $display("[TB] start glitch of 300 cycles");
    @(negedge clk);
    serFull = 1'b0;
    idle(300);
    serFull = 1'b1;
    idle(700);
    checkOutput("glitch_full", 8'(busFull.full), 8'h01);
    checkOutput("glitch_data", busFull.parallel_out, 8'h55);
    checkOutput("glitch_ovr",  8'(busFull.overrun), 8'h00);
    checkOutput("glitch_ferr", 8'(busFull.framing_err), 8'h00);

    $display("[TB] 0xA3 with low stop bit, then 0x0F");
    applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0, 0, 1'b0);
    idle(6);
    checkOutput("a3_ferr", 8'(busFast.framing_err), 8'h01);
    checkOutput("a3_full", 8'(busFast.full), 8'h00);
    checkOutput("a3_data", busFast.parallel_out, 8'h00);
    applyStimulus(1'b1, 8'h0F, 1'b1, 1'b0, 0, 1'b0);
    idle(2);
    checkOutput("f0f_full", 8'(busFast.full), 8'h01);
    checkOutput("f0f_data", busFast.parallel_out, 8'h0F);

    $display("[TB] read in completion cycle of 0x7E");
    applyStimulus(1'b1, 8'h7E, 1'b1, 1'b1, 0, 1'b0);
    idle(2);
    checkOutput("f7e_full", 8'(busFast.full), 8'h01);
    checkOutput("f7e_data", busFast.parallel_out, 8'h7E);
    checkOutput("f7e_ovr",  8'(busFast.overrun), 8'h00);
    checkOutput("f7e_ferr", 8'(busFast.framing_err), 8'h00);
    readPulse();
    checkOutput("f7e_read_full", 8'(busFast.full), 8'h00);

    $display("[TB] 0x12 then 0x34 without read");
    applyStimulus(1'b1, 8'h12, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("f12_full", 8'(busFast.full), 8'h01);
    checkOutput("f12_ovr",  8'(busFast.overrun), 8'h00);
    applyStimulus(1'b1, 8'h34, 1'b1, 1'b0, 0, 1'b0);
    idle(2);
    checkOutput("f34_ovr",  8'(busFast.overrun), 8'h01);
    checkOutput("f34_data", busFast.parallel_out, 8'h34);
    checkOutput("f34_full", 8'(busFast.full), 8'h01);
    readPulse();
    checkOutput("f34_read_full", 8'(busFast.full), 8'h00);
    checkOutput("f34_read_ovr",  8'(busFast.overrun), 8'h00);

    $display("[TB] framing error coinciding with read");
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b1, 0, 1'b0);
    idle(6);
    checkOutput("bad_read_ferr", 8'(busFast.framing_err), 8'h01);
    checkOutput("bad_read_full", 8'(busFast.full), 8'h00);
    checkOutput("bad_read_data", busFast.parallel_out, 8'h34);
    readPulse();
    checkOutput("empty_read_ferr", 8'(busFast.framing_err), 8'h00);
    checkOutput("empty_read_full", 8'(busFast.full), 8'h00);

    $display("[TB] reset during data bit 4");
    applyStimulus(1'b1, 8'hE7, 1'b1, 1'b0, 5 * FAST_BIT + FAST_HALF, 1'b0);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    checkOutput("mid_rst_full", 8'(busFast.full), 8'h00);
    checkOutput("mid_rst_data", busFast.parallel_out, 8'h00);
    checkOutput("mid_rst_ovr",  8'(busFast.overrun), 8'h00);
    checkOutput("mid_rst_ferr", 8'(busFast.framing_err), 8'h00);
    idle(200);
    checkOutput("abandoned_full", 8'(busFast.full), 8'h00);
    applyStimulus(1'b1, 8'hC9, 1'b1, 1'b0, 0, 1'b0);
    idle(2);
    checkOutput("fc9_full", 8'(busFast.full), 8'h01);
    checkOutput("fc9_data", busFast.parallel_out, 8'hC9);
    checkOutput("fc9_ovr",  8'(busFast.overrun), 8'h00);
    checkOutput("fc9_ferr", 8'(busFast.framing_err), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
